// File: rtl/ex_mem_reg.sv
// ex_mem_reg
// EX/MEM pipeline register for the 5-stage core. It also holds the
// architectural N/Z/V flag register.
//
// Ports:
//   clk, rst_n          - clock, asynchronous active-low reset
//   stall               - hold every register and the flags
//   flush               - turn the captured instruction into a bubble
//   ex_*                - execute-stage result, store data, rd and controls
//   mem_*               - the same fields, registered, for the MEM stage
//   flag_n/z/v          - architectural flags, straight from flops
//
// Each edge is resolved in priority order: rst_n, flush, stall, load.
// There is no valid/ready handshake. The upstream stage stalls this
// register explicitly, and ex_valid only qualifies the control bits.
module ex_mem_reg #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall,
    input  logic             flush,
    input  logic             ex_valid,
    input  logic [3:0]       ex_opcode,
    input  logic [WIDTH-1:0] ex_alu_out,
    input  logic             ex_alu_ovf,
    input  logic [WIDTH-1:0] ex_store_data,
    input  logic [3:0]       ex_rd,
    input  logic             ex_reg_write,
    input  logic             ex_mem_read,
    input  logic             ex_mem_write,
    input  logic             ex_halt,
    output logic             mem_valid,
    output logic             mem_reg_write,
    output logic             mem_mem_read,
    output logic             mem_mem_write,
    output logic             mem_halt,
    output logic [WIDTH-1:0] mem_alu_out,
    output logic [WIDTH-1:0] mem_store_data,
    output logic [3:0]       mem_rd,
    output logic             flag_n,
    output logic             flag_z,
    output logic             flag_v
);

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_XOR = 4'b0010;
    localparam logic [3:0] OP_SLL = 4'b0100;
    localparam logic [3:0] OP_SRA = 4'b0101;
    localparam logic [3:0] OP_ROR = 4'b0110;

    logic load;
    logic upd_nzv;   // ADD/SUB: N, Z and V all follow the result
    logic upd_z;     // logical and shift ops: only Z follows the result
    logic ex_zero;

    always_comb begin
        load    = 1'b0;
        upd_nzv = 1'b0;
        upd_z   = 1'b0;
        ex_zero = 1'b0;
        load    = !flush && !stall;
        ex_zero = (ex_alu_out == '0);
        // Flags move only when a real instruction actually loads.
        if (load && ex_valid) begin
            case (ex_opcode)
                OP_ADD, OP_SUB:                 upd_nzv = 1'b1;
                OP_XOR, OP_SLL, OP_SRA, OP_ROR: upd_z   = 1'b1;
                default: ;  // RED, PADDSB, memory, branch: no flag change
            endcase
        end
    end

    // Pipeline fields
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_valid      <= 1'b0;
            mem_reg_write  <= 1'b0;
            mem_mem_read   <= 1'b0;
            mem_mem_write  <= 1'b0;
            mem_halt       <= 1'b0;
            mem_alu_out    <= '0;
            mem_store_data <= '0;
            mem_rd         <= '0;
        end else if (flush) begin
            // A bubble: the controls are cleared and the data fields keep
            // whatever they held.
            mem_valid     <= 1'b0;
            mem_reg_write <= 1'b0;
            mem_mem_read  <= 1'b0;
            mem_mem_write <= 1'b0;
            mem_halt      <= 1'b0;
        end else if (!stall) begin
            mem_valid      <= ex_valid;
            mem_reg_write  <= ex_reg_write & ex_valid;
            mem_mem_read   <= ex_mem_read  & ex_valid;
            mem_mem_write  <= ex_mem_write & ex_valid;
            mem_halt       <= ex_halt      & ex_valid;
            mem_alu_out    <= ex_alu_out;
            mem_store_data <= ex_store_data;
            mem_rd         <= ex_rd;
        end
    end

    // Architectural flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flag_n <= 1'b0;
            flag_z <= 1'b0;
            flag_v <= 1'b0;
        end else if (upd_nzv) begin
            flag_n <= ex_alu_out[WIDTH-1];
            flag_z <= ex_zero;
            flag_v <= ex_alu_ovf;
        end else if (upd_z) begin
            flag_z <= ex_zero;
        end
    end

endmodule
